// File: rtl/psum_pack_ctrl_if.sv
// Neuron-stream and psum-RAM signal bundle for psum_pack_ctrl.
// master = controller side, slave = accumulator/RAM side.
interface psum_pack_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int ADDR_W = 10
);
    logic                    nrn_valid;
    logic                    nrn_ready;
    logic [DATA_W-1:0]       nrn_data;
    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic [DATA_W*LANES-1:0] rd_data;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W*LANES-1:0] wr_data;
    logic                    wr_ready;

    modport master (
        input  nrn_valid, nrn_data, rd_data, wr_ready,
        output nrn_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output nrn_valid, nrn_data, rd_data, wr_ready,
        input  nrn_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/psum_pack_ctrl.sv
// Packs neuron results into LANES-wide psum words; pass 0 writes raw values,
// later passes read-modify-write with signed saturating lane-wise accumulation.
module psum_pack_ctrl #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int ADDR_W = 10,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_words,
    input  logic [PASS_W-1:0] num_passes,
    psum_pack_ctrl_if.master  bus,
    output logic              plane_rdy,
    output logic              busy,
    output logic              done
);
    localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [DATA_W-1:0] SAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_RDW  = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_num_words;
    logic [ADDR_W-1:0] r_word;
    logic [PASS_W-1:0] r_num_passes;
    logic [PASS_W-1:0] r_pass;
    logic [LANE_W-1:0] r_lane;
    logic [DATA_W-1:0] r_lanes [LANES];
    logic [DATA_W-1:0] r_prior [LANES];
    logic              r_plane_rdy;
    logic              r_busy;
    logic              r_done;

    logic              w_xfer;
    logic              w_last_word;
    logic              w_last_pass;
    logic [PASS_W-1:0] w_pass_nxt;
    logic [DATA_W-1:0] w_prior_lane;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_lane_val;

    assign w_xfer      = (r_state == S_FILL) && bus.nrn_valid;
    assign w_last_word = (r_word == r_num_words - ADDR_W'(1));
    assign w_pass_nxt  = r_pass + PASS_W'(1);
    assign w_last_pass = (w_pass_nxt == r_num_passes);

    // One guard bit catches overflow: it disagrees with the lane MSB only when clamped.
    always_comb begin
        w_prior_lane = r_prior[r_lane];
        w_sum        = {w_prior_lane[DATA_W-1], w_prior_lane}
                     + {bus.nrn_data[DATA_W-1], bus.nrn_data};
        if (r_pass == '0)
            w_lane_val = bus.nrn_data;
        else if (w_sum[DATA_W] != w_sum[DATA_W-1])
            w_lane_val = w_sum[DATA_W] ? SAT_MIN : SAT_MAX;
        else
            w_lane_val = w_sum[DATA_W-1:0];
    end

    always_comb begin
        bus.wr_data = '0;
        for (int unsigned i = 0; i < LANES; i++)
            bus.wr_data[(LANES-1-i)*DATA_W +: DATA_W] = r_lanes[i];
    end

    assign bus.nrn_ready = (r_state == S_FILL);
    assign bus.rd_en     = (r_state == S_RD);
    assign bus.rd_addr   = r_word;
    assign bus.wr_en     = (r_state == S_WR);
    assign bus.wr_addr   = r_word;
    assign plane_rdy     = r_plane_rdy;
    assign busy          = r_busy;
    assign done          = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_num_words  <= '0;
            r_word       <= '0;
            r_num_passes <= '0;
            r_pass       <= '0;
            r_lane       <= '0;
            r_lanes      <= '{default: '0};
            r_prior      <= '{default: '0};
            r_plane_rdy  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_plane_rdy <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_words  <= num_words;
                        r_num_passes <= num_passes;
                        r_word       <= '0;
                        r_pass       <= '0;
                        r_lane       <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= (num_words == '0 || num_passes == '0) ? S_FIN : S_FILL;
                    end
                end
                S_RD:  r_state <= S_RDW;
                S_RDW: begin
                    for (int unsigned i = 0; i < LANES; i++)
                        r_prior[i] <= bus.rd_data[(LANES-1-i)*DATA_W +: DATA_W];
                    r_state <= S_FILL;
                end
                S_FILL: begin
                    if (w_xfer) begin
                        r_lanes[r_lane] <= w_lane_val;
                        if (r_lane == LAST_LANE) begin
                            r_lane  <= '0;
                            r_state <= S_WR;
                        end else begin
                            r_lane <= r_lane + LANE_W'(1);
                        end
                    end
                end
                S_WR: begin
                    if (bus.wr_ready) begin
                        if (!w_last_word) begin
                            r_word  <= r_word + ADDR_W'(1);
                            r_state <= (r_pass != '0) ? S_RD : S_FILL;
                        end else begin
                            r_plane_rdy <= 1'b1;
                            r_word      <= '0;
                            r_pass      <= w_pass_nxt;
                            r_state     <= w_last_pass ? S_FIN : S_RD;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_pack_ctrl.sv
// Scoreboard bench for psum_pack_ctrl: expected writes queued with the stimulus,
// observed writes captured by a RAM model and compared in each scenario task.
`timescale 1ns/1ps
module tb_psum_pack_ctrl;
    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int ADDR_W = 10;
    localparam int PASS_W = 8;
    localparam int WORD_W = DATA_W * LANES;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] num_words;
    logic [PASS_W-1:0] num_passes;
    logic              plane_rdy;
    logic              busy;
    logic              done;

    psum_pack_ctrl_if #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

    psum_pack_ctrl #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W), .PASS_W(PASS_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words), .num_passes(num_passes),
        .bus(bus), .plane_rdy(plane_rdy), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    wr_t               exp_q[$];
    wr_t               obs_q[$];
    logic [DATA_W-1:0] nrn_q[$];
    logic [WORD_W-1:0] mem [0:7];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc, stall_left;
    int rd_cnt, rd_seen, plane_cnt, done_cnt, wr_cycles, unstable_cnt, overlap_cnt;
    int acc_cnt, acc4_cyc, wr_first_cyc, rd_cyc, ready_rise_cyc, plane_cyc, done_cyc;
    logic [ADDR_W-1:0] last_rd_addr, prev_wr_addr;
    logic [WORD_W-1:0] prev_wr_data;
    logic              prev_wr_en, prev_wr_ready, prev_ready;

    always @(posedge clk) cyc++;

    // Neuron source: holds nrn_valid/nrn_data until the controller takes it.
    initial begin
        bus.nrn_valid = 1'b0;
        bus.nrn_data  = '0;
        forever begin
            @(posedge clk); #1;
            bus.nrn_valid = !rst && (nrn_q.size() > 0);
            bus.nrn_data  = (nrn_q.size() > 0) ? nrn_q[0] : '0;
        end
    end

    // RAM model: read data valid only in the cycle after rd_en, optional write stall.
    initial begin
        bus.rd_data  = '1;
        bus.wr_ready = 1'b1;
        rd_seen      = 0;
        forever begin
            @(posedge clk); #1;
            if (rd_cnt != rd_seen) begin
                bus.rd_data = mem[last_rd_addr[2:0]];
                rd_seen     = rd_cnt;
            end else begin
                bus.rd_data = '1;
            end
            if (bus.wr_en && stall_left > 0) begin
                bus.wr_ready = 1'b0;
                stall_left--;
            end else begin
                bus.wr_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.nrn_valid && bus.nrn_ready) begin
                void'(nrn_q.pop_front());
                acc_cnt++;
                if (acc_cnt == 4) acc4_cyc = cyc;
            end
            if (bus.rd_en) begin
                rd_cnt++;
                rd_cyc       = cyc;
                last_rd_addr = bus.rd_addr;
            end
            if (bus.nrn_ready && !prev_ready) ready_rise_cyc = cyc;
            if (bus.wr_en) begin
                wr_cycles++;
                if (wr_first_cyc < 0) wr_first_cyc = cyc;
                if (prev_wr_en && !prev_wr_ready &&
                    (bus.wr_addr !== prev_wr_addr || bus.wr_data !== prev_wr_data))
                    unstable_cnt++;
                if (bus.nrn_ready) overlap_cnt++;
                if (bus.wr_ready) begin
                    mem[bus.wr_addr[2:0]] = bus.wr_data;
                    obs_q.push_back({bus.wr_addr, bus.wr_data});
                end
            end
            if (plane_rdy) begin plane_cnt++; plane_cyc = cyc; end
            if (done)      begin done_cnt++;  done_cyc  = cyc; end
            prev_wr_en    = bus.wr_en;
            prev_wr_ready = bus.wr_ready;
            prev_wr_addr  = bus.wr_addr;
            prev_wr_data  = bus.wr_data;
            prev_ready    = bus.nrn_ready;
        end
    end

    task automatic clear_mon();
        exp_q.delete(); obs_q.delete(); nrn_q.delete();
        for (int i = 0; i < 8; i++) mem[i] = '0;
        rd_cnt = 0; plane_cnt = 0; done_cnt = 0; wr_cycles = 0; unstable_cnt = 0;
        overlap_cnt = 0; acc_cnt = 0; acc4_cyc = -1; wr_first_cyc = -1; rd_cyc = -1;
        ready_rise_cyc = -1; plane_cyc = -1; done_cyc = -1; stall_left = 0;
        prev_wr_en = 1'b0; prev_wr_ready = 1'b1; prev_ready = 1'b0;
    endtask

    task automatic pulse_start(input int nw, input int np);
        @(posedge clk); #1;
        start_cyc  = cyc;
        start      = 1'b1;
        num_words  = ADDR_W'(nw);
        num_passes = PASS_W'(np);
        @(posedge clk); #1;
        start      = 1'b0;
        num_words  = '1;
        num_passes = '1;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        int n0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #1;
            if (done_cnt != n0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_words = '0; num_passes = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0)          begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (plane_rdy !== 1'b0)     begin errors++; $display("FAIL reset_plane_rdy: got %b required 0", plane_rdy); end
        checks++; if (bus.nrn_ready !== 1'b0) begin errors++; $display("FAIL reset_nrn_ready: got %b required 0", bus.nrn_ready); end
        checks++; if (bus.rd_en !== 1'b0)     begin errors++; $display("FAIL reset_rd_en: got %b required 0", bus.rd_en); end
        checks++; if (bus.wr_en !== 1'b0)     begin errors++; $display("FAIL reset_wr_en: got %b required 0", bus.wr_en); end
        checks++; if (bus.wr_addr !== '0)     begin errors++; $display("FAIL reset_wr_addr: got %h required 0", bus.wr_addr); end
        checks++; if (bus.wr_data !== '0)     begin errors++; $display("FAIL reset_wr_data: got %h required 0", bus.wr_data); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_pass();
        bit ok;
        clear_mon();
        for (int i = 1; i <= 8; i++) nrn_q.push_back(DATA_W'(i));
        exp_q.push_back({10'd0, 64'h0001_0002_0003_0004});
        exp_q.push_back({10'd1, 64'h0005_0006_0007_0008});
        pulse_start(2, 1);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_done: got no done required done within 200 cycles"); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL single_wr_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            wr_t o = obs_q.pop_front();
            wr_t e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL single_wr: got addr %0d data %h required addr %0d data %h", o.addr, o.data, e.addr, e.data); end
        end
        checks++; if (plane_cnt != 1) begin errors++; $display("FAIL single_plane_rdy: got %0d required 1", plane_cnt); end
        checks++; if (rd_cnt != 0)    begin errors++; $display("FAIL single_rd_en: got %0d required 0", rd_cnt); end
        checks++; if (done_cyc != plane_cyc + 1) begin errors++; $display("FAIL single_done_after_plane: got cycle %0d required %0d", done_cyc, plane_cyc + 1); end
        checks++; if (wr_first_cyc != acc4_cyc + 1) begin errors++; $display("FAIL single_wr_latency: got cycle %0d required %0d", wr_first_cyc, acc4_cyc + 1); end
    endtask

    task automatic test_accumulate();
        bit ok;
        logic [DATA_W-1:0] d [8] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd1, 16'd2, 16'd3, 16'd4};
        clear_mon();
        foreach (d[i]) nrn_q.push_back(d[i]);
        exp_q.push_back({10'd0, 64'h000A_0014_001E_0028});
        exp_q.push_back({10'd0, 64'h000B_0016_0021_002C});
        pulse_start(1, 2);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL accum_done: got no done required done within 200 cycles"); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL accum_wr_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            wr_t o = obs_q.pop_front();
            wr_t e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL accum_wr: got addr %0d data %h required addr %0d data %h", o.addr, o.data, e.addr, e.data); end
        end
        checks++; if (rd_cnt != 1)        begin errors++; $display("FAIL accum_rd_count: got %0d required 1", rd_cnt); end
        checks++; if (last_rd_addr !== '0) begin errors++; $display("FAIL accum_rd_addr: got %0d required 0", last_rd_addr); end
        checks++; if (plane_cnt != 2)     begin errors++; $display("FAIL accum_plane_rdy: got %0d required 2", plane_cnt); end
        checks++; if (ready_rise_cyc != rd_cyc + 2) begin errors++; $display("FAIL accum_ready_latency: got cycle %0d required %0d", ready_rise_cyc, rd_cyc + 2); end
    endtask

    task automatic test_saturation();
        bit ok;
        logic [DATA_W-1:0] d [8] = '{16'h7FF0, 16'h8010, 16'h7FF0, 16'h8010,
                                     16'h0100, 16'hFF00, 16'hFF00, 16'h0100};
        clear_mon();
        foreach (d[i]) nrn_q.push_back(d[i]);
        exp_q.push_back({10'd0, 64'h7FF0_8010_7FF0_8010});
        exp_q.push_back({10'd0, 64'h7FFF_8000_7EF0_8110});
        pulse_start(1, 2);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_done: got no done required done within 200 cycles"); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL sat_wr_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            wr_t o = obs_q.pop_front();
            wr_t e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL sat_wr: got addr %0d data %h required addr %0d data %h", o.addr, o.data, e.addr, e.data); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_mon();
        for (int i = 0; i < 8; i++) nrn_q.push_back(DATA_W'(16'h0A00 + i));
        exp_q.push_back({10'd0, 64'h0A00_0A01_0A02_0A03});
        exp_q.push_back({10'd1, 64'h0A04_0A05_0A06_0A07});
        stall_left = 5;
        pulse_start(2, 1);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done: got no done required done within 200 cycles"); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_wr_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            wr_t o = obs_q.pop_front();
            wr_t e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL bp_wr: got addr %0d data %h required addr %0d data %h", o.addr, o.data, e.addr, e.data); end
        end
        checks++; if (wr_cycles != 7)    begin errors++; $display("FAIL bp_wr_en_cycles: got %0d required 7", wr_cycles); end
        checks++; if (unstable_cnt != 0) begin errors++; $display("FAIL bp_stable: got %0d changes required 0", unstable_cnt); end
        checks++; if (overlap_cnt != 0)  begin errors++; $display("FAIL bp_nrn_ready: got %0d cycles ready during write required 0", overlap_cnt); end
    endtask

    task automatic test_degenerate();
        bit ok;
        int cfg [2][2] = '{'{0, 3}, '{2, 0}};
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            pulse_start(cfg[k][0], cfg[k][1]);
            @(negedge clk);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL degen_busy: case %0d got %b required 1", k, busy); end
            wait_done(20, ok);
            checks++; if (!ok) begin errors++; $display("FAIL degen_done: case %0d got no done required done within 20 cycles", k); end
            checks++; if (done_cyc != start_cyc + 2) begin errors++; $display("FAIL degen_done_latency: case %0d got cycle %0d required %0d", k, done_cyc, start_cyc + 2); end
            checks++; if (wr_cycles != 0 || rd_cnt != 0) begin errors++; $display("FAIL degen_no_access: case %0d got wr %0d rd %0d required 0 0", k, wr_cycles, rd_cnt); end
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        clear_mon();
        for (int i = 0; i < 8; i++) nrn_q.push_back(DATA_W'(16'h0011 + i));
        exp_q.push_back({10'd0, 64'h0011_0012_0013_0014});
        exp_q.push_back({10'd1, 64'h0015_0016_0017_0018});
        pulse_start(2, 1);
        repeat (3) @(posedge clk);
        pulse_start(1, 3);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ignore_done: got no done required done within 200 cycles"); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ignore_wr_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            wr_t o = obs_q.pop_front();
            wr_t e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL ignore_wr: got addr %0d data %h required addr %0d data %h", o.addr, o.data, e.addr, e.data); end
        end
        checks++; if (plane_cnt != 1 || rd_cnt != 0) begin errors++; $display("FAIL ignore_passes: got plane %0d rd %0d required 1 0", plane_cnt, rd_cnt); end
        repeat (3) @(posedge clk);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count: got %0d required 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        clear_mon();
        nrn_q.push_back(16'h0005);
        nrn_q.push_back(16'h0006);
        pulse_start(1, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (acc_cnt == 2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_fill: got %0d transfers required 2 within 50 cycles", acc_cnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({busy, done, plane_rdy, bus.nrn_ready, bus.rd_en, bus.wr_en} !== 6'b0)
            begin errors++; $display("FAIL rstmid_ctrl: got %b required 000000", {busy, done, plane_rdy, bus.nrn_ready, bus.rd_en, bus.wr_en}); end
        checks++; if (bus.wr_data !== '0) begin errors++; $display("FAIL rstmid_wr_data: got %h required 0", bus.wr_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_mon();
        for (int i = 7; i <= 10; i++) nrn_q.push_back(DATA_W'(i));
        exp_q.push_back({10'd0, 64'h0007_0008_0009_000A});
        pulse_start(1, 1);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_done: got no done required done within 200 cycles"); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_wr_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            wr_t o = obs_q.pop_front();
            wr_t e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL rstmid_wr: got addr %0d data %h required addr %0d data %h", o.addr, o.data, e.addr, e.data); end
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_accumulate();
        test_saturation();
        test_backpressure();
        test_degenerate();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
